// File: rtl/sp_frame_arbiter_if.sv
// Bundle of requester-side and SP-side signals for the SP frame arbiter.
// The master modport is the arbiter; the slave modport is the requesters plus the SP engine.
interface sp_frame_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [3*N_REQ-1:0] req_mode;
  logic [9*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   data_rd;
  logic               sp_in_valid;
  logic [2:0]         sp_in_mode;
  logic [8:0]         sp_in_data;
  logic               sp_out_valid;
  logic [9:0]         sp_out_data;
  logic [N_REQ-1:0]   rsp_valid;
  logic [9:0]         rsp_data;
  logic               rsp_last;
  logic               err_timeout;
  logic               busy;

  modport master (
    input  req, req_mode, req_data, sp_out_valid, sp_out_data,
    output gnt, data_rd, sp_in_valid, sp_in_mode, sp_in_data,
           rsp_valid, rsp_data, rsp_last, err_timeout, busy
  );

  modport slave (
    output req, req_mode, req_data, sp_out_valid, sp_out_data,
    input  gnt, data_rd, sp_in_valid, sp_in_mode, sp_in_data,
           rsp_valid, rsp_data, rsp_last, err_timeout, busy
  );
endinterface

// File: rtl/sp_frame_arbiter.sv
// Round-robin arbiter that streams one requester's 9-sample frame into a shared SP
// engine, returns its 3-beat result to that requester, and aborts on a silent SP.
module sp_frame_arbiter_lane (
  input  logic       sel_i,
  input  logic       ld_i,
  input  logic       fwd_i,
  input  logic [2:0] mode_i,
  input  logic [8:0] data_i,
  output logic       gnt_o,
  output logic       rd_o,
  output logic       rsp_o,
  output logic [2:0] mode_o,
  output logic [8:0] data_o
);
  assign gnt_o  = sel_i;
  assign rd_o   = sel_i & ld_i;
  assign rsp_o  = sel_i & fwd_i;
  assign mode_o = sel_i ? mode_i : 3'd0;
  assign data_o = sel_i ? data_i : 9'd0;
endmodule

module sp_frame_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 15
) (
  input logic               clk,
  input logic               rst,
  sp_frame_arbiter_if.master io
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int CW    = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [3:0]         beat_q, beat_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               found;
  logic [IDX_W-1:0]   sel;
  logic               ld, fwd, last, tmo, busy;
  logic [N_REQ-1:0]   sel_vec;
  logic [N_REQ-1:0][2:0] lane_mode;
  logic [N_REQ-1:0][8:0] lane_data;
  logic [2:0]         mode_or;
  logic [8:0]         data_or;

  assign busy = (state_q != IDLE);

  // First requester at or after rr_ptr, wrapping upward.
  always_comb begin
    int j;
    found = 1'b0;
    sel   = '0;
    j     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(rr_ptr_q) + k) % N_REQ;
      if (!found && io.req[IDX_W'(j)]) begin
        found = 1'b1;
        sel   = IDX_W'(j);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gidx_d   = gidx_q;
    rr_ptr_d = rr_ptr_q;
    beat_d   = beat_q;
    cnt_d    = cnt_q;
    ld       = 1'b0;
    fwd      = 1'b0;
    last     = 1'b0;
    tmo      = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        gidx_d   = sel;
        rr_ptr_d = (sel == IDX_W'(N_REQ - 1)) ? '0 : sel + IDX_W'(1);
        beat_d   = 4'd0;
        state_d  = LOAD;
      end
      LOAD: begin
        ld = 1'b1;
        if (beat_q == 4'd8) begin
          state_d = WAIT;
          beat_d  = 4'd0;
          cnt_d   = '0;
        end else begin
          beat_d = beat_q + 4'd1;
        end
      end
      WAIT: begin
        if (io.sp_out_valid) begin
          fwd     = 1'b1;
          state_d = DRAIN;
          beat_d  = 4'd1;
          cnt_d   = '0;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          tmo     = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        // A gap between result beats re-arms the watchdog from zero.
        if (io.sp_out_valid) begin
          fwd   = 1'b1;
          cnt_d = '0;
          if (beat_q == 4'd2) begin
            last    = 1'b1;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + 4'd1;
          end
        end else if (cnt_q == CW'(TIMEOUT)) begin
          tmo     = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
      beat_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      gidx_q   <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
      beat_q   <= beat_d;
      cnt_q    <= cnt_d;
    end
  end

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign sel_vec[i] = busy && (gidx_q == IDX_W'(i));
    sp_frame_arbiter_lane u_lane (
      .sel_i  (sel_vec[i]),
      .ld_i   (ld),
      .fwd_i  (fwd),
      .mode_i (io.req_mode[3*i +: 3]),
      .data_i (io.req_data[9*i +: 9]),
      .gnt_o  (io.gnt[i]),
      .rd_o   (io.data_rd[i]),
      .rsp_o  (io.rsp_valid[i]),
      .mode_o (lane_mode[i]),
      .data_o (lane_data[i])
    );
  end

  always_comb begin
    mode_or = '0;
    data_or = '0;
    for (int i = 0; i < N_REQ; i++) begin
      mode_or = mode_or | lane_mode[i];
      data_or = data_or | lane_data[i];
    end
  end

  // Mode rides only on the first beat of a frame.
  assign io.sp_in_valid = ld;
  assign io.sp_in_mode  = (ld && beat_q == 4'd0) ? mode_or : 3'd0;
  assign io.sp_in_data  = ld ? data_or : 9'd0;
  assign io.rsp_data    = fwd ? io.sp_out_data : 10'd0;
  assign io.rsp_last    = last;
  assign io.err_timeout = tmo;
  assign io.busy        = busy;
endmodule
